sm_cmult_seq: RTL and testbench

Sequential complex multiplier for the FFT butterfly datapath: multiplies data sample b = Reb + j·Imb by twiddle w = Rew + j·Imw, all operands signed two's complement. Each operand is split into sign and unsigned magnitude, four magnitude products are formed by N-cycle shift-add, signs are reapplied and partial products combined, then rounded and saturated back to N bits. The block sits between the butterfly input registers and the butterfly adder stage. It uses a valid/ready handshake on both sides and has one operation in flight at a time.

---
 rtl/sm_cmult_seq.sv | 190 +++++++++++++++++++
 tb/tb_sm_cmult_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_cmult_seq.sv
// sm_cmult_seq: sequential complex multiplier b * w for the FFT butterfly.
// The operands are held as sign plus magnitude. The four magnitude products are
// built by N-cycle shift-add. Signs are then reapplied, and the result is rounded
// half up and saturated back to N bits. Only one operation is in flight at a time.
module sm_cmult_seq #(
    parameter int unsigned N    = 8,
    parameter int unsigned FRAC = N - 1
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] Reb,
    input  logic [N-1:0] Imb,
    input  logic [N-1:0] Rew,
    input  logic [N-1:0] Imw,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] ReOut,
    output logic [N-1:0] ImOut,
    output logic         Sat
);

    localparam int unsigned PW  = 2 * N;
    localparam int unsigned SW  = 2 * N + 1;
    localparam int unsigned VW  = 2 * N + 2;
    localparam int unsigned CW  = $clog2(N);
    localparam int unsigned RSH = (FRAC == 0) ? 0 : FRAC - 1;

    localparam logic signed [VW-1:0] RND  = (FRAC == 0) ? VW'(0) : (VW'(1) << RSH);
    localparam logic signed [VW-1:0] MAXV = (VW'(1) << (N - 1)) - VW'(1);
    localparam logic signed [VW-1:0] MINV = -(VW'(1) << (N - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        COMB = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic          sgn_a, sgn_b, sgn_c, sgn_d;
    logic [N-1:0]  mag_a, mag_b, mag_c, mag_d;
    logic [PW-1:0] acc_ac, acc_bd, acc_ad, acc_bc;
    logic [CW-1:0] cnt;

    logic signed [SW-1:0] p_ac, p_bd, p_ad, p_bc;
    logic signed [VW-1:0] re_v, im_v;
    logic [N:0]           re_rs, im_rs;

    // Unsigned magnitude of a two's complement value (-2^(N-1) maps to 2^(N-1)).
    function automatic logic [N-1:0] mag_of(input logic [N-1:0] x);
        return x[N-1] ? (~x + N'(1)) : x;
    endfunction

    // One shift-add step, driven by multiplier bit number sh.
    function automatic logic [PW-1:0] shift_add(input logic [PW-1:0] acc,
                                                input logic [N-1:0]  mcand,
                                                input logic          mbit,
                                                input logic [CW-1:0] sh);
        return mbit ? (acc + (PW'(mcand) << sh)) : acc;
    endfunction

    // Reapply the product sign to an unsigned magnitude product.
    function automatic logic signed [SW-1:0] signed_prod(input logic          neg,
                                                         input logic [PW-1:0] p);
        logic signed [SW-1:0] v;
        v = signed'({1'b0, p});
        return neg ? -v : v;
    endfunction

    // Round half up, then clamp. The MSB of the return value flags saturation.
    function automatic logic [N:0] round_sat(input logic signed [VW-1:0] v);
        logic signed [VW-1:0] r;
        r = (v + RND) >>> FRAC;
        if (r > MAXV) begin
            return {1'b1, MAXV[N-1:0]};
        end else if (r < MINV) begin
            return {1'b1, MINV[N-1:0]};
        end
        return {1'b0, r[N-1:0]};
    endfunction

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MUL;
            MUL:     if (cnt == CW'(N - 1)) state_next = COMB;
            COMB:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the state decode they stand for.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Operand capture and the four shift-add multipliers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            sgn_c  <= 1'b0;
            sgn_d  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            mag_c  <= '0;
            mag_d  <= '0;
            acc_ac <= '0;
            acc_bd <= '0;
            acc_ad <= '0;
            acc_bc <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn_a  <= Reb[N-1];
                        sgn_b  <= Imb[N-1];
                        sgn_c  <= Rew[N-1];
                        sgn_d  <= Imw[N-1];
                        mag_a  <= mag_of(Reb);
                        mag_b  <= mag_of(Imb);
                        mag_c  <= mag_of(Rew);
                        mag_d  <= mag_of(Imw);
                        acc_ac <= '0;
                        acc_bd <= '0;
                        acc_ad <= '0;
                        acc_bc <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    acc_ac <= shift_add(acc_ac, mag_a, mag_c[cnt], cnt);
                    acc_bd <= shift_add(acc_bd, mag_b, mag_d[cnt], cnt);
                    acc_ad <= shift_add(acc_ad, mag_a, mag_d[cnt], cnt);
                    acc_bc <= shift_add(acc_bc, mag_b, mag_c[cnt], cnt);
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Signed recombination, rounding and saturation of the finished products.
    always_comb begin
        p_ac  = signed_prod(sgn_a ^ sgn_c, acc_ac);
        p_bd  = signed_prod(sgn_b ^ sgn_d, acc_bd);
        p_ad  = signed_prod(sgn_a ^ sgn_d, acc_ad);
        p_bc  = signed_prod(sgn_b ^ sgn_c, acc_bc);
        re_v  = VW'(p_ac) - VW'(p_bd);
        im_v  = VW'(p_ad) + VW'(p_bc);
        re_rs = round_sat(re_v);
        im_rs = round_sat(im_v);
    end

    // Result registers: loaded in COMB, held otherwise.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ReOut <= '0;
            ImOut <= '0;
            Sat   <= 1'b0;
        end else if (state == COMB) begin
            ReOut <= re_rs[N-1:0];
            ImOut <= im_rs[N-1:0];
            Sat   <= re_rs[N] | im_rs[N];
        end
    end

endmodule

// File: tb/tb_sm_cmult_seq.sv
// tb_sm_cmult_seq: directed N=8 checks plus a randomized N=12 sweep with
// out_ready stalls, both compared against an integer reference model.
module tb_sm_cmult_seq;

    localparam int NA = 8;
    localparam int FA = 7;
    localparam int NB = 12;
    localparam int FB = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          a_iv, a_ir, a_ov, a_or, a_sat;
    logic [NA-1:0] a_reb, a_imb, a_rew, a_imw, a_reo, a_imo;

    logic          b_iv, b_ir, b_ov, b_or, b_sat;
    logic [NB-1:0] b_reb, b_imb, b_rew, b_imw, b_reo, b_imo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint re;
        longint im;
        logic   sat;
    } exp_t;

    exp_t sb[$];
    int   mcyc  = 0;
    int   macc  = 0;
    bit   mbusy = 1'b0;
    bit   b_rand = 1'b0;

    sm_cmult_seq #(.N(NA), .FRAC(FA)) u_a (
        .Clock(clk), .nReset(rst_n),
        .in_valid(a_iv), .in_ready(a_ir),
        .Reb(a_reb), .Imb(a_imb), .Rew(a_rew), .Imw(a_imw),
        .out_valid(a_ov), .out_ready(a_or),
        .ReOut(a_reo), .ImOut(a_imo), .Sat(a_sat)
    );

    sm_cmult_seq #(.N(NB), .FRAC(FB)) u_b (
        .Clock(clk), .nReset(rst_n),
        .in_valid(b_iv), .in_ready(b_ir),
        .Reb(b_reb), .Imb(b_imb), .Rew(b_rew), .Imw(b_imw),
        .out_valid(b_ov), .out_ready(b_or),
        .ReOut(b_reo), .ImOut(b_imo), .Sat(b_sat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact complex product, round half up at bit f, clamp to n bits.
    function automatic void model(input int n, input int f,
                                  input longint a, input longint b,
                                  input longint c, input longint d,
                                  output longint re, output longint im, output logic sat);
        longint rnd, hi, lo, vr, vi;
        rnd = (f > 0) ? (longint'(1) << (f - 1)) : longint'(0);
        hi  = (longint'(1) << (n - 1)) - 1;
        lo  = -(longint'(1) << (n - 1));
        vr  = (a * c - b * d + rnd) >>> f;
        vi  = (a * d + b * c + rnd) >>> f;
        sat = 1'b0;
        re  = vr;
        im  = vi;
        if (vr > hi) begin re = hi; sat = 1'b1; end
        if (vr < lo) begin re = lo; sat = 1'b1; end
        if (vi > hi) begin im = hi; sat = 1'b1; end
        if (vi < lo) begin im = lo; sat = 1'b1; end
    endfunction

    // One N=8 operation, entered and left at posedge+1; optionally leaves DONE held.
    task automatic a_op(input string tag, input int reb, input int imb, input int rew,
                        input int imw, input int exp_re, input int exp_im,
                        input bit exp_sat, input bit release_out);
        int t;
        int lat;
        longint mr, mi;
        logic ms;
        a_reb = NA'(reb);
        a_imb = NA'(imb);
        a_rew = NA'(rew);
        a_imw = NA'(imw);
        a_iv  = 1'b1;
        t = 0;
        while (!a_ir && t < 50) begin @(posedge clk); #1; t++; end
        chk({tag, "_accept_wait"}, longint'(t < 50), 1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        lat = 1;
        while (!a_ov && lat < 60) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency_cycles"}, lat, NA + 2);
        model(NA, FA, reb, imb, rew, imw, mr, mi, ms);
        chk({tag, "_re"}, longint'($signed(a_reo)), exp_re);
        chk({tag, "_im"}, longint'($signed(a_imo)), exp_im);
        chk({tag, "_sat"}, longint'(a_sat), longint'(exp_sat));
        chk({tag, "_re_model"}, longint'($signed(a_reo)), mr);
        chk({tag, "_im_model"}, longint'($signed(a_imo)), mi);
        chk({tag, "_sat_model"}, longint'(a_sat), longint'(ms));
        chk({tag, "_in_ready_busy"}, longint'(a_ir), 0);
        if (release_out) begin
            @(posedge clk); #1;
            chk({tag, "_out_valid_after"}, longint'(a_ov), 0);
            chk({tag, "_in_ready_after"}, longint'(a_ir), 1);
        end
    endtask

    // out_ready stall generator for the sweep instance.
    initial begin
        b_or = 1'b1;
        forever begin
            @(posedge clk); #1;
            b_or = b_rand ? (($urandom % 3) != 0) : 1'b1;
        end
    end

    // Per-cycle compare of the N=12 instance against the transaction-level model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                mbusy = 1'b0;
                sb.delete();
            end
            chk("b_in_ready", longint'(b_ir), longint'(!mbusy));
            chk("b_out_valid", longint'(b_ov), longint'(mbusy && (mcyc - macc >= NB + 2)));
            if (b_ov) begin
                chk("b_result_pending", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("b_re", longint'($signed(b_reo)), sb[0].re);
                    chk("b_im", longint'($signed(b_imo)), sb[0].im);
                    chk("b_sat", longint'(b_sat), longint'(sb[0].sat));
                end
            end
            if (mbusy && (mcyc - macc >= NB + 2) && b_or) begin
                if (sb.size() > 0) void'(sb.pop_front());
                mbusy = 1'b0;
            end else if (!mbusy && b_iv && rst_n) begin
                model(NB, FB, longint'($signed(b_reb)), longint'($signed(b_imb)),
                      longint'($signed(b_rew)), longint'($signed(b_imw)), e.re, e.im, e.sat);
                sb.push_back(e);
                mbusy = 1'b1;
                macc  = mcyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NA-1:0] s_re, s_im;
        logic s_sat;
        int t;
        int sel;

        rst_n = 1'b0;
        a_iv  = 1'b1;
        a_or  = 1'b1;
        b_iv  = 1'b0;
        {a_reb, a_imb, a_rew, a_imw} = '0;
        {b_reb, b_imb, b_rew, b_imw} = '0;
        a_reb = NA'(64);
        a_rew = NA'(64);

        // in_valid is high throughout reset and must not start anything.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_in_ready", longint'(a_ir), 1);
        chk("rst_a_out_valid", longint'(a_ov), 0);
        chk("rst_a_reout", longint'(a_reo), 0);
        chk("rst_a_imout", longint'(a_imo), 0);
        chk("rst_a_sat", longint'(a_sat), 0);
        chk("rst_b_in_ready", longint'(b_ir), 1);
        chk("rst_b_out_valid", longint'(b_ov), 0);
        a_iv  = 1'b0;
        rst_n = 1'b1;

        // 64*64 = 4096 -> (4096+64)>>7 = 32.
        a_op("basic", 64, 0, 64, 0, 32, 0, 1'b0, 1'b1);
        // 16384 -> 128, clamps to 127.
        a_op("negmax_re", -128, 0, -128, 0, 127, 0, 1'b1, 1'b1);
        // re = 0, im = 32768 -> 256, clamps to 127.
        a_op("negmax_all", -128, -128, -128, -128, 0, 127, 1'b1, 1'b1);

        // Backpressure: re = 11000 -> 86, im = -500 -> floor(-3.40625) = -4.
        a_or = 1'b0;
        a_op("bp", 100, -50, 90, 40, 86, -4, 1'b0, 1'b0);
        s_re  = a_reo;
        s_im  = a_imo;
        s_sat = a_sat;
        for (int k = 0; k < 6; k++) begin
            a_iv  = 1'b1;
            a_reb = NA'($urandom);
            a_imb = NA'($urandom);
            a_rew = NA'($urandom);
            a_imw = NA'($urandom);
            @(posedge clk); #1;
            chk("bp_hold_re", longint'(a_reo), longint'(s_re));
            chk("bp_hold_im", longint'(a_imo), longint'(s_im));
            chk("bp_hold_sat", longint'(a_sat), longint'(s_sat));
            chk("bp_hold_out_valid", longint'(a_ov), 1);
            chk("bp_hold_in_ready", longint'(a_ir), 0);
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        @(posedge clk); #1;
        chk("bp_xfer_out_valid", longint'(a_ov), 0);
        chk("bp_xfer_in_ready", longint'(a_ir), 1);
        chk("bp_xfer_re_kept", longint'(a_reo), longint'(s_re));

        // re = -6144 -> -48, im = 2048 -> 16.
        a_op("mixed", 64, 32, -64, 64, -48, 16, 1'b0, 1'b1);

        // Reset while the bit counter is at 3.
        a_reb = NA'(64);
        a_imb = NA'(0);
        a_rew = NA'(64);
        a_imw = NA'(0);
        a_iv  = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(a_ov), 0);
        chk("midrst_in_ready", longint'(a_ir), 1);
        chk("midrst_reout", longint'(a_reo), 0);
        chk("midrst_imout", longint'(a_imo), 0);
        chk("midrst_sat", longint'(a_sat), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // re = -4064 + 16 = -4048 -> floor(-31.125) = -32; im = 32 + 2032 = 2064 -> 16.
        a_op("post_reset", -32, 16, 127, -1, -32, 16, 1'b0, 1'b1);

        // Randomized N=12 sweep, including exact rounding ties and extremes.
        b_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                b_reb = ($urandom % 2) ? NB'(1024) : NB'(-1024);
                b_imb = NB'(0);
                b_rew = NB'($urandom) | NB'(1);
                b_imw = NB'($urandom) | NB'(1);
            end else if (sel == 1) begin
                b_reb = ($urandom % 2) ? NB'(-2048) : NB'(2047);
                b_imb = ($urandom % 2) ? NB'(-2048) : NB'(2047);
                b_rew = ($urandom % 2) ? NB'(-2048) : NB'(2047);
                b_imw = ($urandom % 2) ? NB'(-2048) : NB'(2047);
            end else begin
                b_reb = NB'($urandom);
                b_imb = NB'($urandom);
                b_rew = NB'($urandom);
                b_imw = NB'($urandom);
            end
            b_iv = 1'b1;
            t = 0;
            @(negedge clk);
            while (!b_ir && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) begin
                chk("b_accept_timeout", t, 0);
                break;
            end
            @(posedge clk); #1;
            b_iv = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        t = 0;
        while ((sb.size() != 0 || mbusy) && t < 500) begin @(posedge clk); t++; end
        chk("b_drain", longint'(sb.size()), 0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
